stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Controller that sequences the cascaded counter/7-segment datapath as a start/stop/lap/reset stopwatch. It converts two debounced push-button levels into press events, runs a four-state FSM, and drives the counter chain's count-enable (`cin` of the least-significant stage) and active-low clear. It also drives a lap-hold/latch interface for the display path. It sits between the chattering removers and the counter chain in the top level.

## Interface
- `TICK_DIV`, 500000: `clk` cycles per count tick (50 MHz gives 100 Hz); legal range is ≥ 2.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `nclr`  in  1  asynchronous, active-low reset.
- `btn_ss`  in  1  start/stop button, debounced level, active-low (0 = pressed); asynchronous to `clk`.
- `btn_lr`  in  1  lap/reset button, debounced level, active-low; asynchronous to `clk`.
- `cnt_en`  out  1  one-cycle count pulse to the counter chain `cin`.
- `cnt_nclr`  out  1  active-low clear to the counter chain.
- `lap_load`  out  1  one-cycle pulse; the display latch captures the live count.
- `lap_hold`  out  1  1 = display shows the latched value; 0 = display shows the live count.
- `state`  out  2  current FSM state, for debug LEDs.
- `running`  out  1  1 while the counter is advancing (state RUN or LAP).

## Operation
- Button front end, per button:
  - Two-flop synchronizer, then a previous-value register.
  - Press event = synchronized value 0 while previous value is 1 (falling edge). Release generates nothing.
  - All three flops reset to 1, so reset never creates a false press.
- FSM states: IDLE=2'b00, RUN=2'b01, STOP=2'b10, LAP=2'b11. Reset state is IDLE.
  - IDLE: `ss` → RUN; `lr` is ignored.
  - RUN: `ss` → STOP; `lr` → LAP and fires `lap_load` in the same edge.
  - LAP: `ss` → STOP and `lap_hold` drops; `lr` → RUN and `lap_hold` drops. Counting continues while in LAP.
  - STOP: `ss` → RUN; `lr` → IDLE with a clear pulse.
  - Simultaneous `ss` and `lr` events in one cycle: `ss` wins and the `lr` event is discarded.
- Prescaler: ceil(log2(`TICK_DIV`)) bits.
  - Increments in RUN/LAP, wrapping from `TICK_DIV`-1 to 0.
  - Forced to 0 in IDLE/STOP, so resuming discards the partial tick.
- `cnt_en` is registered: 1 for one cycle when the current state is RUN/LAP and the prescaler equals `TICK_DIV`-1.
  - A tick that coincides with a stop press is still issued.
- `cnt_nclr` is registered: 0 for exactly one cycle, on the edge the FSM enters IDLE from STOP; 1 otherwise. `cnt_en` is 0 in that cycle.
- `lap_hold` is registered and equals (state == LAP).
- `running` is registered and equals (state == RUN or state == LAP).

## Timing
- Reset values:
  - `state` = IDLE.
  - `cnt_en`, `lap_load`, `lap_hold`, `running` = 0.
  - `cnt_nclr` = 0 while `nclr` is low, then 1 from the first `clk` edge after reset release. Reset therefore also clears the counter chain.
- Button latency:
  - A level change sampled at edge E1 reaches sync2 at E2.
  - The FSM and outputs update at E3: three edges from the input to the visible state.
- First `cnt_en` after entering RUN: asserted `TICK_DIV` cycles after the state update; period is `TICK_DIV` cycles thereafter.
- `lap_load` is high in the cycle after the RUN→LAP edge. `lap_hold` rises on the same edge.
- `nclr` asserted mid-count: all state, prescaler and outputs return to their reset values immediately (asynchronous); no partial pulses survive.

## Structure
- Shared include `sw_defs.vh` holds the state encodings `SW_IDLE`, `SW_RUN`, `SW_STOP`, `SW_LAP`, which the display/top logic also uses.
- Sub-module `btn_edge(clk, nclr, din_n, press)` contains the synchronizer and falling-edge detector. It is instantiated twice.
- The FSM, prescaler and output registers live in `stopwatch_ctrl`.

## Test plan
- Reset: hold `nclr` low with buttons at 1.
  - During reset: `state`=0, `cnt_nclr`=0.
  - After release: `cnt_nclr`=1 at the first edge; no `cnt_en` for 20 cycles.
- Start (`TICK_DIV`=4): press `btn_ss` for 10 cycles.
  - `state`=RUN at E3 and `running`=1.
  - `cnt_en` pulses every 4 cycles, first pulse 4 cycles after entry.
  - Releasing the button causes no transition.
- Lap: in RUN, press `btn_lr`.
  - `lap_load`=1 for exactly one cycle; `lap_hold`=1.
  - `cnt_en` continues every 4 cycles.
  - A second `lr` press returns to RUN with `lap_hold`=0.
- Stop and clear: RUN → `ss` gives STOP.
  - `cnt_en` stays 0 for 50 cycles and `running`=0.
  - `lr` gives IDLE with `cnt_nclr`=0 for exactly one cycle.
- Simultaneous presses: both buttons fall in the same cycle from IDLE.
  - Result is RUN (not LAP); no `lap_load`.
- Mid-operation reset: assert `nclr` in LAP for 2 cycles.
  - Outputs drop to reset values asynchronously.
  - After release, `state`=IDLE and `lap_hold`=0.

Source files
------------

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared stopwatch state encodings and the button-driven next-state rule,
// also used by the display/top logic.
package stopwatch_ctrl_pkg;

   typedef enum logic [1:0] {
      SW_IDLE = 2'b00,
      SW_RUN  = 2'b01,
      SW_STOP = 2'b10,
      SW_LAP  = 2'b11
   } sw_state_e;

   // A start/stop press always takes priority over a lap/reset press.
   function automatic sw_state_e sw_next(input sw_state_e cur, input logic ss, input logic lr);
      sw_state_e nxt;
      nxt = cur;
      case (cur)
         SW_IDLE: if (ss) nxt = SW_RUN;
         SW_RUN:  if (ss) nxt = SW_STOP; else if (lr) nxt = SW_LAP;
         SW_LAP:  if (ss) nxt = SW_STOP; else if (lr) nxt = SW_RUN;
         SW_STOP: if (ss) nxt = SW_RUN;  else if (lr) nxt = SW_IDLE;
         default: nxt = SW_IDLE;
      endcase
      return nxt;
   endfunction

   function automatic logic sw_counting(input sw_state_e s);
      return (s == SW_RUN) || (s == SW_LAP);
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and counter-chain / display-latch controls of the stopwatch.
interface stopwatch_ctrl_if;
   logic       btn_ss;
   logic       btn_lr;
   logic       cnt_en;
   logic       cnt_nclr;
   logic       lap_load;
   logic       lap_hold;
   logic [1:0] state;
   logic       running;

   modport master (
      input  btn_ss, btn_lr,
      output cnt_en, cnt_nclr, lap_load, lap_hold, state, running
   );

   modport slave (
      output btn_ss, btn_lr,
      input  cnt_en, cnt_nclr, lap_load, lap_hold, state, running
   );
endinterface

// File: rtl/stopwatch_ctrl_btn_edge.sv
// Two-flop synchronizer plus falling-edge detector for an active-low button.
// All flops reset high so leaving reset never looks like a press.
module btn_edge (
   input  logic clk,
   input  logic nclr,
   input  logic din_n,
   output logic press
);
   logic sync1;
   logic sync2;
   logic prev;

   always_ff @(posedge clk or negedge nclr) begin
      if (!nclr) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         prev  <= 1'b1;
      end else begin
         sync1 <= din_n;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign press = ~sync2 & prev;
endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/stop/lap/reset stopwatch sequencer driving the counter chain and lap latch.
//   state | meaning
//   IDLE  | cleared, not counting
//   RUN   | counting, display live
//   STOP  | halted, count kept
//   LAP   | counting, display shows latched lap value
module stopwatch_ctrl
   import stopwatch_ctrl_pkg::*;
#(
   parameter int TICK_DIV = 500000
) (
   input  logic             clk,
   input  logic             nclr,
   stopwatch_ctrl_if.master bus
);
   localparam int            PW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic            ss_press;
   logic            lr_press;
   sw_state_e       state_q;
   sw_state_e       state_d;
   logic [PW-1:0]   presc;
   logic            cnt_en_q;
   logic            cnt_nclr_q;
   logic            lap_load_q;
   logic            lap_hold_q;
   logic            running_q;

   btn_edge u_ss (.clk(clk), .nclr(nclr), .din_n(bus.btn_ss), .press(ss_press));
   btn_edge u_lr (.clk(clk), .nclr(nclr), .din_n(bus.btn_lr), .press(lr_press));

   assign state_d = sw_next(state_q, ss_press, lr_press);

   // Ticks depend on the state before this edge, so a tick landing on a stop press still goes out.
   always_ff @(posedge clk or negedge nclr) begin
      if (!nclr) begin
         state_q    <= SW_IDLE;
         presc      <= '0;
         cnt_en_q   <= 1'b0;
         cnt_nclr_q <= 1'b0;
         lap_load_q <= 1'b0;
         lap_hold_q <= 1'b0;
         running_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         if (sw_counting(state_q))
            presc <= (presc == LAST) ? '0 : presc + PW'(1);
         else
            presc <= '0;
         cnt_en_q   <= sw_counting(state_q) && (presc == LAST);
         cnt_nclr_q <= !((state_q == SW_STOP) && (state_d == SW_IDLE));
         lap_load_q <= (state_q == SW_RUN) && (state_d == SW_LAP);
         lap_hold_q <= (state_d == SW_LAP);
         running_q  <= sw_counting(state_d);
      end
   end

   assign bus.state    = state_q;
   assign bus.cnt_en   = cnt_en_q;
   assign bus.cnt_nclr = cnt_nclr_q;
   assign bus.lap_load = lap_load_q;
   assign bus.lap_hold = lap_hold_q;
   assign bus.running  = running_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Stopwatch controller bench: directed scenarios with literal expectations,
// then random button activity, all compared every cycle against a behavioural model.
module tb_stopwatch_ctrl;
   localparam int TD = 4;

   logic clk = 1'b0;
   logic nclr = 1'b0;
   int   errors = 0;
   int   checks = 0;

   stopwatch_ctrl_if bus ();

   stopwatch_ctrl #(.TICK_DIV(TD)) dut (
      .clk (clk),
      .nclr(nclr),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: state codes 0=IDLE 1=RUN 2=STOP 3=LAP
   int m_state, m_phase;
   bit m_en, m_nclr_o, m_load, m_hold, m_run;
   bit ssq[3], lrq[3];

   task automatic m_reset();
      m_state = 0; m_phase = 0;
      m_en = 0; m_nclr_o = 0; m_load = 0; m_hold = 0; m_run = 0;
      for (int i = 0; i < 3; i++) begin ssq[i] = 1; lrq[i] = 1; end
   endtask

   task automatic m_step(input bit ss_in, input bit lr_in);
      bit ss, lr, counting;
      int nxt;
      // ssq[0] = level seen one edge ago, ssq[1] two ago, ssq[2] three ago
      ss = !ssq[1] && ssq[2];
      lr = !lrq[1] && lrq[2] && !ss;
      counting = (m_state == 1) || (m_state == 3);
      m_en = counting && (m_phase == TD - 1);
      m_phase = counting ? (m_phase + 1) % TD : 0;
      nxt = m_state;
      if (ss) nxt = counting ? 2 : 1;
      else if (lr) begin
         if (m_state == 1) nxt = 3;
         else if (m_state == 3) nxt = 1;
         else if (m_state == 2) nxt = 0;
      end
      m_nclr_o = !(m_state == 2 && nxt == 0);
      m_load = (m_state == 1 && nxt == 3);
      m_state = nxt;
      m_hold = (nxt == 3);
      m_run = (nxt == 1) || (nxt == 3);
      ssq[2] = ssq[1]; ssq[1] = ssq[0]; ssq[0] = ss_in;
      lrq[2] = lrq[1]; lrq[1] = lrq[0]; lrq[0] = lr_in;
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk);
         if (nclr) m_step(bus.btn_ss, bus.btn_lr);
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!nclr) m_reset();
         chk("model_state",    {30'd0, bus.state}, m_state);
         chk("model_cnt_en",   bus.cnt_en,   m_en);
         chk("model_cnt_nclr", bus.cnt_nclr, m_nclr_o);
         chk("model_lap_load", bus.lap_load, m_load);
         chk("model_lap_hold", bus.lap_hold, m_hold);
         chk("model_running",  bus.running,  m_run);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic count_en(input int n, output int c);
      c = 0;
      repeat (n) begin
         cyc(1);
         c += int'(bus.cnt_en);
      end
   endtask

   int c;

   initial begin
      bus.btn_ss = 1'b1;
      bus.btn_lr = 1'b1;
      nclr = 1'b0;
      cyc(3);
      chk("rst_state", {30'd0, bus.state}, 0);
      chk("rst_cnt_nclr", bus.cnt_nclr, 0);
      nclr = 1'b1;
      cyc(1);
      chk("rel_cnt_nclr", bus.cnt_nclr, 1);
      count_en(20, c);
      chk("idle_no_en", c, 0);

      // start
      bus.btn_ss = 1'b0;
      cyc(2);
      chk("start_e2_state", {30'd0, bus.state}, 0);
      cyc(1);
      chk("start_e3_state", {30'd0, bus.state}, 1);
      chk("start_running", bus.running, 1);
      cyc(3);
      chk("start_en_early", bus.cnt_en, 0);
      cyc(1);
      chk("start_first_en", bus.cnt_en, 1);
      cyc(1);
      chk("start_en_one", bus.cnt_en, 0);
      cyc(2);
      bus.btn_ss = 1'b1;
      count_en(20, c);
      chk("run_en_count", c, 5);
      chk("release_state", {30'd0, bus.state}, 1);

      // lap
      bus.btn_lr = 1'b0;
      cyc(3);
      chk("lap_state", {30'd0, bus.state}, 3);
      chk("lap_load", bus.lap_load, 1);
      chk("lap_hold", bus.lap_hold, 1);
      cyc(1);
      chk("lap_load_one", bus.lap_load, 0);
      cyc(2);
      bus.btn_lr = 1'b1;
      count_en(20, c);
      chk("lap_en_count", c, 5);
      bus.btn_lr = 1'b0;
      cyc(3);
      chk("unlap_state", {30'd0, bus.state}, 1);
      chk("unlap_hold", bus.lap_hold, 0);
      cyc(2);
      bus.btn_lr = 1'b1;
      cyc(3);

      // stop and clear
      bus.btn_ss = 1'b0;
      cyc(3);
      chk("stop_state", {30'd0, bus.state}, 2);
      chk("stop_running", bus.running, 0);
      cyc(2);
      bus.btn_ss = 1'b1;
      count_en(50, c);
      chk("stop_no_en", c, 0);
      bus.btn_lr = 1'b0;
      cyc(3);
      chk("clr_state", {30'd0, bus.state}, 0);
      chk("clr_pulse", bus.cnt_nclr, 0);
      chk("clr_no_en", bus.cnt_en, 0);
      cyc(1);
      chk("clr_pulse_end", bus.cnt_nclr, 1);
      cyc(1);
      bus.btn_lr = 1'b1;
      cyc(4);

      // simultaneous presses from IDLE
      bus.btn_ss = 1'b0;
      bus.btn_lr = 1'b0;
      cyc(3);
      chk("simul_state", {30'd0, bus.state}, 1);
      chk("simul_no_load", bus.lap_load, 0);
      cyc(1);
      chk("simul_no_load2", bus.lap_load, 0);
      chk("simul_no_hold", bus.lap_hold, 0);
      bus.btn_ss = 1'b1;
      bus.btn_lr = 1'b1;
      cyc(4);

      // reset while in LAP
      bus.btn_lr = 1'b0;
      cyc(3);
      chk("pre_rst_lap", {30'd0, bus.state}, 3);
      bus.btn_lr = 1'b1;
      cyc(5);
      nclr = 1'b0;
      #1;
      chk("arst_state", {30'd0, bus.state}, 0);
      chk("arst_hold", bus.lap_hold, 0);
      chk("arst_running", bus.running, 0);
      chk("arst_cnt_nclr", bus.cnt_nclr, 0);
      chk("arst_cnt_en", bus.cnt_en, 0);
      chk("arst_load", bus.lap_load, 0);
      cyc(2);
      nclr = 1'b1;
      cyc(1);
      chk("post_rst_state", {30'd0, bus.state}, 0);
      chk("post_rst_hold", bus.lap_hold, 0);
      chk("post_rst_cnt_nclr", bus.cnt_nclr, 1);

      // random button activity
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) < 2) begin
            nclr = 1'b0;
            cyc($urandom_range(1, 2));
            nclr = 1'b1;
            cyc(1);
         end else begin
            bus.btn_ss = ($urandom_range(0, 3) != 0);
            bus.btn_lr = ($urandom_range(0, 2) != 0);
            cyc($urandom_range(1, 12));
         end
      end
      bus.btn_ss = 1'b1;
      bus.btn_lr = 1'b1;
      cyc(5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
